// File: rtl/pattern_scan_controller.sv
// Frame-based serial pattern scanner: bytes are shifted MSB first through a 4-bit window
// and matches against a latched pattern are counted. Define PATTERN_OVERLAP_EN to count overlapping matches.
module pattern_scan_controller #(
  parameter int FRAME_BYTES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] pattern_in,
  input  logic       in_valid,
  input  logic [7:0] data_in,
  output logic       in_ready,
  output logic       busy,
  output logic       match_pulse,
  output logic [7:0] match_count,
  output logic       done
);

  // state     | meaning
  // IDLE      | waiting for start, match_count holds last frame result
  // WAIT_BYTE | ready for the next frame byte
  // SHIFT     | shifting 8 bits of the current byte into the window
  // DONE      | one-cycle end-of-frame indication
  typedef enum logic [1:0] {IDLE, WAIT_BYTE, SHIFT, DONE} state_t;

  localparam logic [7:0] LAST_BYTE = 8'(FRAME_BYTES - 1);

  state_t     state, state_nxt;
  logic [3:0] pattern;
  logic [3:0] window, window_nxt;
  logic [2:0] fill, fill_nxt;
  logic [7:0] shift_reg;
  logic [2:0] bit_cnt;
  logic [7:0] byte_cnt;
  logic       hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (start) state_nxt = WAIT_BYTE;
      WAIT_BYTE: if (in_valid) state_nxt = SHIFT;
      SHIFT:     if (bit_cnt == 3'd0) state_nxt = (byte_cnt == 8'd0) ? DONE : WAIT_BYTE;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == WAIT_BYTE);
    busy     = (state != IDLE);
    done     = (state == DONE);
  end

  // fill saturates at 4: only "at least four bits since clear" matters
  always_comb begin
    window_nxt = {window[2:0], shift_reg[7]};
    fill_nxt   = (fill == 3'd4) ? 3'd4 : fill + 3'd1;
    hit        = (state == SHIFT) && (window_nxt == pattern) && (fill_nxt == 3'd4);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pattern     <= 4'd0;
      window      <= 4'd0;
      fill        <= 3'd0;
      shift_reg   <= 8'd0;
      bit_cnt     <= 3'd0;
      byte_cnt    <= 8'd0;
      match_count <= 8'd0;
      match_pulse <= 1'b0;
    end else begin
      match_pulse <= hit;
      case (state)
        IDLE: begin
          if (start) begin
            pattern     <= pattern_in;
            window      <= 4'd0;
            fill        <= 3'd0;
            bit_cnt     <= 3'd0;
            byte_cnt    <= LAST_BYTE;
            match_count <= 8'd0;
          end
        end
        WAIT_BYTE: begin
          if (in_valid) begin
            shift_reg <= data_in;
            bit_cnt   <= 3'd7;
          end
        end
        SHIFT: begin
          shift_reg <= {shift_reg[6:0], 1'b0};
          if (bit_cnt != 3'd0)       bit_cnt  <= bit_cnt - 3'd1;
          else if (byte_cnt != 8'd0) byte_cnt <= byte_cnt - 8'd1;
          if (hit && match_count != 8'hFF) match_count <= match_count + 8'd1;
`ifdef PATTERN_OVERLAP_EN
          window <= window_nxt;
          fill   <= fill_nxt;
`else
          window <= hit ? 4'd0 : window_nxt;
          fill   <= hit ? 3'd0 : fill_nxt;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/pattern_scan_controller.md
PATTERN_SCAN_CONTROLLER -- requirements
Module: pattern_scan_controller

Interface
REQ-001 The parameter list SHALL be: FRAME_BYTES, default 4, number of bytes per scan frame, legal range 1..255.
REQ-002 The ports SHALL be, one per line:
- clk  input  1  sole clock, rising-edge active
- reset  input  1  asynchronous, active-low reset
- start  input  1  frame start request, sampled in IDLE only
- pattern_in  input  4  target pattern, latched on accepted start
- in_valid  input  1  data_in holds a valid byte
- data_in  input  8  frame byte, shifted out MSB first
- in_ready  output  1  controller accepts a byte this cycle
- busy  output  1  frame in progress (any state other than IDLE)
- match_pulse  output  1  one-cycle pulse per detected pattern
- match_count  output  8  matches in the current or last frame
- done  output  1  one-cycle end-of-frame pulse
REQ-003 Clocking and reset SHALL be one clock (clk) and an asynchronous, active-low reset (reset); polarity and synchronicity are fixed.

Function
REQ-004 The FSM SHALL have the states IDLE, WAIT_BYTE, SHIFT and DONE.
REQ-005 In IDLE, start=1 at a rising edge SHALL latch pattern_in, clear the 4-bit window, fill counter, byte counter and match_count, and enter WAIT_BYTE.
REQ-006 start SHALL be ignored in every state other than IDLE.
REQ-007 in_ready SHALL be 1 only in WAIT_BYTE (combinational from state).
REQ-008 When in_valid=1 and in_ready=1 at an edge, data_in SHALL be loaded into an 8-bit shift register and the FSM SHALL enter SHIFT; without in_valid the FSM SHALL stay in WAIT_BYTE indefinitely.
REQ-009 Each SHIFT cycle SHALL shift one bit, MSB first, into the window: window <= {window[2:0], bit}, for exactly 8 cycles per byte.
REQ-010 A match SHALL be detected on a shift edge when the new window equals the latched pattern and at least 4 bits have entered the window since it was last cleared.
REQ-011 On a match edge, match_pulse SHALL be registered high for exactly one cycle and match_count SHALL increment.
REQ-012 match_count SHALL saturate at 255.
REQ-013 The window and fill count SHALL persist across byte boundaries within a frame.
REQ-014 After the 8th bit of byte FRAME_BYTES-1 the FSM SHALL enter DONE; otherwise it SHALL return to WAIT_BYTE.
REQ-015 done SHALL be 1 for the single cycle spent in DONE; the FSM SHALL then return to IDLE.
REQ-016 match_count SHALL hold its value in IDLE until the next accepted start.
REQ-017 With in_valid held high, done SHALL assert in the cycle following the edge 9*FRAME_BYTES cycles after the start-sampling edge.
REQ-018 A start asserted in the DONE cycle SHALL be ignored; start is honoured only from IDLE.

Reset
REQ-019 reset=0 SHALL asynchronously force state IDLE; in_ready=0, busy=0, match_pulse=0, done=0, match_count=0; window, shift register and all counters to 0.
REQ-020 Reset asserted mid-frame SHALL abort the frame with no done pulse; the first start after reset release starts a fresh frame.

Configuration
REQ-021 Macro PATTERN_OVERLAP_EN, when defined, SHALL count overlapping matches: the window and fill count are unaffected by a match.
REQ-022 When PATTERN_OVERLAP_EN is undefined, a match SHALL clear the window and fill count on the match edge (non-overlapping counting).

Verification
REQ-023 FRAME_BYTES=1, pattern 1101, byte 0xDD -> match_pulse after bits 4 and 8, match_count=2 in both configurations.
REQ-024 FRAME_BYTES=1, pattern 1010, byte 0xAA -> match_count=3 with PATTERN_OVERLAP_EN, 2 without.
REQ-025 FRAME_BYTES=2, pattern 0110, bytes 0x01 then 0x80 -> single match on bit 2 of byte 2 (cross-byte), match_count=1; done 18 cycles after the start edge with in_valid held high.
REQ-026 in_valid deasserted for 5 cycles between bytes -> in_ready stays 1 and state stays WAIT_BYTE; start pulses while busy change nothing.
REQ-027 reset pulsed low during SHIFT of byte 2 -> all outputs 0 immediately and no done pulse; a following start with FRAME_BYTES=1, pattern 1111, byte 0xFF -> match_count=5 (overlap) or 2 (non-overlap).
